// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, VGA active area and the RGB bit layout of a stored pixel.
package fb_pkg;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int R_BIT    = 2;
    localparam int G_BIT    = 1;
    localparam int B_BIT    = 0;
endpackage

// File: rtl/fb_scan_addr_gen.sv
// fb_scan_addr_gen: frame-buffer scan address; the line base advances by FB_W after every
// second visible line, so each stored line is read twice.
module fb_scan_addr_gen #(
    parameter int FB_W   = fb_pkg::FB_W,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              display_enable,
    output logic [ADDR_W-1:0] scan_addr
);
    import fb_pkg::*;

    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic              de_q;
    logic              de_fall;

    assign de_fall   = de_q && !display_enable;
    assign scan_addr = rd_base_q + ADDR_W'(hcount[9:1]);

    always_comb begin
        rd_base_d = (vcount == '0 && !display_enable) ? '0 :
                    (de_fall && vcount[0])            ? rd_base_q + ADDR_W'(FB_W) : rd_base_q;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            rd_base_q <= '0;
            de_q      <= 1'b0;
        end else begin
            rd_base_q <= rd_base_d;
            de_q      <= display_enable;
        end
    end
endmodule

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares a single-port frame-buffer BRAM between 2x2-scaled VGA scanout and a
// pixel writer. Define FB_VBLANK_ONLY_WR_EN to accept writes only during vertical blanking.
module fb_scanout_arbiter #(
    parameter int FB_W     = fb_pkg::FB_W,
    parameter int FB_H     = fb_pkg::FB_H,
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              display_enable,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [7:0]        bram_wdata,
    input  logic [7:0]        bram_rdata,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic [15:0]       wr_drop_cnt
);
    import fb_pkg::*;

`ifdef FB_VBLANK_ONLY_WR_EN
    localparam logic VBLANK_ONLY = 1'b1;
`else
    localparam logic VBLANK_ONLY = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_W * FB_H);

    logic [ADDR_W-1:0] scan_addr, addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [15:0]       wr_drop_q, drop_d;
    logic [1:0]        rd_q;
    logic [2:0]        pix_q, pix;
    logic [1:0]        de_sr_q, hs_sr_q, vs_sr_q;
    logic              de_q, hs_q, vs_q;
    logic [7:0]        r_q, g_q, b_q;
    logic              read_slot, wr_fire, wr_in_range;
    logic              unused_rdata;

    fb_scan_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_scan (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .hcount         (hcount),
        .vcount         (vcount),
        .display_enable (display_enable),
        .scan_addr      (scan_addr)
    );

    assign read_slot    = display_enable && !hcount[0];
    assign wr_ready     = !read_slot && !reset && (!VBLANK_ONLY || vcount >= 10'(V_ACTIVE));
    assign wr_fire      = wr_valid && wr_ready;
    assign wr_in_range  = wr_addr < DEPTH;
    // rd_q[1] marks the cycle whose bram_rdata answers an even-column read
    assign pix          = rd_q[1] ? bram_rdata[2:0] : pix_q;
    assign unused_rdata = ^bram_rdata[7:3];

    always_comb begin
        addr_d  = read_slot ? scan_addr : (wr_fire ? wr_addr : addr_q);
        we_d    = wr_fire && wr_in_range;
        wdata_d = wr_fire ? wr_data : wdata_q;
        drop_d  = (wr_fire && !wr_in_range && wr_drop_q != 16'hFFFF) ? wr_drop_q + 16'd1 : wr_drop_q;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wr_drop_q <= '0;
            rd_q      <= '0;
            pix_q     <= '0;
            de_sr_q   <= '0;
            hs_sr_q   <= '1;
            vs_sr_q   <= '1;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wr_drop_q <= drop_d;
            rd_q      <= {rd_q[0], read_slot};
            pix_q     <= pix;
            de_sr_q   <= {de_sr_q[0], display_enable};
            hs_sr_q   <= {hs_sr_q[0], hsync};
            vs_sr_q   <= {vs_sr_q[0], vsync};
            de_q      <= de_sr_q[1];
            hs_q      <= hs_sr_q[1];
            vs_q      <= vs_sr_q[1];
            r_q       <= de_sr_q[1] ? {8{pix[R_BIT]}} : '0;
            g_q       <= de_sr_q[1] ? {8{pix[G_BIT]}} : '0;
            b_q       <= de_sr_q[1] ? {8{pix[B_BIT]}} : '0;
        end
    end

    assign bram_addr   = addr_q;
    assign bram_we     = we_q;
    assign bram_wdata  = wdata_q;
    assign wr_drop_cnt = wr_drop_q;
    assign de_o        = de_q;
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
endmodule
